// File: rtl/icache_line_fill.sv
// icache_line_fill
// ----------------
// Bus-side fill engine for the L1 instruction cache. On a miss it issues a
// single line-read request to the Sysbus arbiter, accepts BEATS response
// beats of BUS_DATA_WIDTH bits each, and assembles them into a LINE_BITS line.
// out_offset counts received bits. It reaches LINE_BITS only when a fill
// completes without being aborted. The instruction cache waits for that value
// before writing a way.
//
// Ports
//   clk          clock
//   reset        synchronous reset, active low
//   in_miss      icache miss (level, held until the line is written)
//   in_pc        miss address
//   in_hold      icache stalled; keeps the completed line presented
//   in_flush     abort the current fill (redirect)
//   bus_reqcyc   request valid
//   bus_req      line-aligned request address
//   bus_reqtag   request tag (memory read)
//   bus_reqack   request accepted by the arbiter
//   bus_respcyc  response beat valid
//   bus_resp     response beat data
//   bus_resptag  response tag (unused: only one request is ever outstanding)
//   bus_respack  response beat accepted (combinational)
//   out_data     assembled line
//   out_offset   bits received so far; LINE_BITS means the line is complete
//   out_busy     engine not idle
module icache_line_fill #(
  parameter int                       BUS_DATA_WIDTH = 64,
  parameter int                       BUS_TAG_WIDTH  = 13,
  parameter int                       LINE_BITS      = 512,
  parameter logic [BUS_TAG_WIDTH-1:0] REQ_TAG        = 13'h1100
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_miss,
  input  logic [BUS_DATA_WIDTH-1:0] in_pc,
  input  logic                      in_hold,
  input  logic                      in_flush,
  output logic                      bus_reqcyc,
  output logic [BUS_DATA_WIDTH-1:0] bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  input  logic                      bus_reqack,
  input  logic                      bus_respcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  output logic                      bus_respack,
  output logic [LINE_BITS-1:0]      out_data,
  output logic [9:0]                out_offset,
  output logic                      out_busy
);

  localparam int         BEATS         = LINE_BITS / BUS_DATA_WIDTH;
  localparam int         BEAT_W        = $clog2(BEATS);
  localparam int         LINE_OFF_BITS = $clog2(LINE_BITS / 8);
  localparam logic [9:0] OFF_STEP      = 10'(BUS_DATA_WIDTH);
  localparam logic [9:0] OFF_FULL      = 10'(LINE_BITS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic                        r_reqcyc;
  logic [BUS_DATA_WIDTH-1:0]   r_req;
  logic [BUS_TAG_WIDTH-1:0]    r_reqtag;
  logic [LINE_BITS-1:0]        r_data;
  logic [9:0]                  r_offset;
  logic [9:0]                  w_offset_nxt;
  logic                        r_busy;
  logic [BEAT_W-1:0]           r_beat;
  logic                        r_abort;
  logic                        w_beat_acc;
  logic                        w_last_beat;
  logic                        w_abort_now;
  logic                        w_start;
  logic                        w_unused;

  // Low address bits are dropped by line alignment; the response tag carries
  // no information while a single request is in flight.
  assign w_unused = ^{in_pc[LINE_OFF_BITS-1:0], bus_resptag};

  assign w_beat_acc  = (r_state == S_RESP) && bus_respcyc;
  assign w_last_beat = w_beat_acc && (r_beat == BEAT_W'(BEATS - 1));
  // A flush arriving on the final beat still cancels the completion pulse.
  assign w_abort_now = r_abort | in_flush;
  assign w_start     = (r_state == S_IDLE) && (w_state_nxt == S_REQ);

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (in_miss && !in_flush) w_state_nxt = S_REQ;
      end
      S_REQ: begin
        // An ack that coincides with a flush still commits the request; the
        // beats must be drained, so the flush is recorded as an abort instead.
        if (bus_reqack)    w_state_nxt = S_RESP;
        else if (in_flush) w_state_nxt = S_IDLE;
      end
      S_RESP: begin
        if (w_last_beat) w_state_nxt = w_abort_now ? S_IDLE : S_DONE;
      end
      S_DONE: begin
        if (!in_hold) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic: combinational response ack and next offset value
  always_comb begin
    bus_respack  = w_beat_acc;
    w_offset_nxt = r_offset;
    case (r_state)
      S_IDLE: w_offset_nxt = '0;
      S_REQ:  w_offset_nxt = r_offset;
      S_RESP: begin
        if (w_beat_acc) begin
          if (w_last_beat && w_abort_now) w_offset_nxt = '0;
          else                            w_offset_nxt = r_offset + OFF_STEP;
        end
      end
      S_DONE: w_offset_nxt = (w_state_nxt == S_IDLE) ? 10'd0 : OFF_FULL;
      default: w_offset_nxt = '0;
    endcase
  end

  // Registered outputs and datapath
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_reqcyc <= 1'b0;
      r_req    <= '0;
      r_reqtag <= '0;
      r_data   <= '0;
      r_offset <= '0;
      r_busy   <= 1'b0;
      r_beat   <= '0;
      r_abort  <= 1'b0;
    end else begin
      r_reqcyc <= (w_state_nxt == S_REQ);
      r_reqtag <= (w_state_nxt == S_REQ) ? REQ_TAG : '0;
      r_busy   <= (w_state_nxt != S_IDLE);
      r_offset <= w_offset_nxt;

      if (w_start) begin
        r_req <= {in_pc[BUS_DATA_WIDTH-1:LINE_OFF_BITS], {LINE_OFF_BITS{1'b0}}};
      end

      // Beat counter wraps back to zero after the last beat of a line.
      if (w_start) begin
        r_beat <= '0;
      end else if (w_beat_acc) begin
        r_beat <= r_beat + 1'b1;
      end

      for (int k = 0; k < BEATS; k++) begin
        if (w_beat_acc && (r_beat == BEAT_W'(k))) begin
          r_data[k*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] <= bus_resp;
        end
      end

      if (w_state_nxt == S_IDLE || w_start) begin
        r_abort <= 1'b0;
      end else if ((r_state == S_REQ && bus_reqack && in_flush) ||
                   (r_state == S_RESP && in_flush)) begin
        r_abort <= 1'b1;
      end
    end
  end

  assign bus_reqcyc = r_reqcyc;
  assign bus_req    = r_req;
  assign bus_reqtag = r_reqtag;
  assign out_data   = r_data;
  assign out_offset = r_offset;
  assign out_busy   = r_busy;

endmodule

// File: tb/tb_icache_line_fill.sv
module tb_icache_line_fill;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_miss;
  logic [63:0]  in_pc;
  logic         in_hold;
  logic         in_flush;
  logic         bus_reqcyc;
  logic [63:0]  bus_req;
  logic [12:0]  bus_reqtag;
  logic         bus_reqack;
  logic         bus_respcyc;
  logic [63:0]  bus_resp;
  logic [12:0]  bus_resptag;
  logic         bus_respack;
  logic [511:0] out_data;
  logic [9:0]   out_offset;
  logic         out_busy;

  always #5 clk = ~clk;

  icache_line_fill dut (
    .clk         (clk),
    .reset       (reset),
    .in_miss     (in_miss),
    .in_pc       (in_pc),
    .in_hold     (in_hold),
    .in_flush    (in_flush),
    .bus_reqcyc  (bus_reqcyc),
    .bus_req     (bus_req),
    .bus_reqtag  (bus_reqtag),
    .bus_reqack  (bus_reqack),
    .bus_respcyc (bus_respcyc),
    .bus_resp    (bus_resp),
    .bus_resptag (bus_resptag),
    .bus_respack (bus_respack),
    .out_data    (out_data),
    .out_offset  (out_offset),
    .out_busy    (out_busy)
  );

  typedef struct {
    logic [9:0]   off;
    logic [511:0] data;
  } exp_t;

  exp_t         sb[$];
  logic [511:0] m_line;
  int           n_vec = 0;
  int           n_err = 0;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, out_busy, 1'b0);
    chk({tag, "_reqcyc"}, bus_reqcyc, 1'b0);
    chk({tag, "_offset"}, out_offset, 10'd0);
  endtask

  task automatic req_phase(input logic [63:0] pc, input int ack_wait);
    logic [63:0] aligned;
    aligned = {pc[63:6], 6'b0};
    in_miss = 1'b1;
    in_pc   = pc;
    tick();
    chk("req_cyc", bus_reqcyc, 1'b1);
    chk("req_addr", bus_req, aligned);
    chk("req_tag", bus_reqtag, 13'h1100);
    chk("req_busy", out_busy, 1'b1);
    chk("req_offset", out_offset, 10'd0);
    chk("req_data_held", out_data, m_line);
    for (int i = 0; i < ack_wait; i++) begin
      tick();
      chk("req_cyc_held", bus_reqcyc, 1'b1);
      chk("req_addr_held", bus_req, aligned);
    end
    bus_reqack = 1'b1;
    tick();
    bus_reqack = 1'b0;
    chk("req_cyc_drop", bus_reqcyc, 1'b0);
    chk("resp_busy", out_busy, 1'b1);
  endtask

  task automatic beat(input int k, input logic [63:0] d, input bit abort);
    exp_t e;
    bus_respcyc = 1'b1;
    bus_resp    = d;
    #1;
    chk("respack", bus_respack, 1'b1);
    m_line[k*64 +: 64] = d;
    if (k == 7) e.off = abort ? 10'd0 : 10'd512;
    else        e.off = 10'((k + 1) * 64);
    e.data = m_line;
    sb.push_back(e);
    @(posedge clk);
    #1;
    bus_respcyc = 1'b0;
    e = sb.pop_front();
    chk($sformatf("beat%0d_offset", k), out_offset, e.off);
    chk($sformatf("beat%0d_data", k), out_data, e.data);
  endtask

  task automatic gap(input logic [9:0] exp_off);
    bus_respcyc = 1'b0;
    #1;
    chk("gap_respack", bus_respack, 1'b0);
    tick();
    chk("gap_offset", out_offset, exp_off);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b0;
    in_miss     = 1'b0;
    in_pc       = '0;
    in_hold     = 1'b0;
    in_flush    = 1'b0;
    bus_reqack  = 1'b0;
    bus_respcyc = 1'b0;
    bus_resp    = '0;
    bus_resptag = '0;
    m_line      = '0;

    // Reset state
    tick();
    tick();
    chk("rst_reqcyc", bus_reqcyc, 1'b0);
    chk("rst_req", bus_req, 64'd0);
    chk("rst_reqtag", bus_reqtag, 13'd0);
    chk("rst_data", out_data, 512'd0);
    chk("rst_offset", out_offset, 10'd0);
    chk("rst_busy", out_busy, 1'b0);
    reset = 1'b1;
    tick();

    // Stray beat while idle is ignored
    bus_respcyc = 1'b1;
    bus_resp    = 64'hdead;
    #1;
    chk("stray_respack", bus_respack, 1'b0);
    tick();
    bus_respcyc = 1'b0;
    chk_idle("stray");

    // Basic fill: request held for three cycles, eight back-to-back beats
    req_phase(64'h1_0044, 2);
    for (int k = 0; k < 8; k++) beat(k, 64'((k + 1) * 64'h11), 1'b0);
    chk("basic_lo", out_data[63:0], 64'h11);
    chk("basic_hi", out_data[511:448], 64'h88);
    in_miss = 1'b0;
    tick();
    chk_idle("basic_done");
    tick();
    chk_idle("basic_stay");
    chk("basic_data_held", out_data, m_line);

    // Gapped response: three idle cycles between beats 3 and 4
    req_phase(64'h2_00ff, 0);
    for (int k = 0; k < 4; k++) beat(k, 64'h2000 + 64'(k), 1'b0);
    for (int g = 0; g < 3; g++) gap(10'd256);
    for (int k = 4; k < 8; k++) beat(k, 64'h2000 + 64'(k), 1'b0);
    in_miss = 1'b0;
    tick();
    chk_idle("gap_done");

    // Hold extension: completion presented for five cycles
    req_phase(64'h3_0000, 1);
    for (int k = 0; k < 8; k++) beat(k, {32'hcafe0000, 32'(k)}, 1'b0);
    in_miss = 1'b0;
    in_hold = 1'b1;
    for (int h = 0; h < 4; h++) begin
      tick();
      chk("hold_offset", out_offset, 10'd512);
      chk("hold_busy", out_busy, 1'b1);
    end
    in_hold = 1'b0;
    tick();
    chk_idle("hold_done");

    // Flush while the request is pending
    in_miss = 1'b1;
    in_pc   = 64'h4_0010;
    tick();
    tick();
    chk("freq_reqcyc", bus_reqcyc, 1'b1);
    in_flush = 1'b1;
    in_miss  = 1'b0;
    tick();
    in_flush = 1'b0;
    chk_idle("freq");
    tick();
    chk_idle("freq_stay");
    chk("freq_data_held", out_data, m_line);

    // Flush mid-response after beat 2: drain, no completion
    req_phase(64'h5_0040, 0);
    for (int k = 0; k < 3; k++) beat(k, 64'h5500 + 64'(k), 1'b0);
    in_flush = 1'b1;
    in_miss  = 1'b0;
    gap(10'd192);
    in_flush = 1'b0;
    for (int k = 3; k < 8; k++) beat(k, 64'h5500 + 64'(k), 1'b1);
    chk("fresp_idle", out_busy, 1'b0);
    tick();
    chk_idle("fresp_stay");

    // A following miss fills normally
    req_phase(64'h6_0080, 1);
    for (int k = 0; k < 8; k++) beat(k, 64'h6600 + 64'(k), 1'b0);
    in_miss = 1'b0;
    tick();
    chk_idle("refill_done");

    // Reset mid-response after beat 4
    req_phase(64'h7_0000, 0);
    for (int k = 0; k < 5; k++) beat(k, 64'h7700 + 64'(k), 1'b0);
    reset   = 1'b0;
    in_miss = 1'b0;
    tick();
    reset  = 1'b1;
    m_line = '0;
    chk("mrst_reqcyc", bus_reqcyc, 1'b0);
    chk("mrst_req", bus_req, 64'd0);
    chk("mrst_reqtag", bus_reqtag, 13'd0);
    chk("mrst_data", out_data, 512'd0);
    chk("mrst_offset", out_offset, 10'd0);
    chk("mrst_busy", out_busy, 1'b0);
    for (int k = 5; k < 8; k++) begin
      bus_respcyc = 1'b1;
      bus_resp    = 64'h7700 + 64'(k);
      #1;
      chk("mrst_respack", bus_respack, 1'b0);
      tick();
      chk("mrst_offset_hold", out_offset, 10'd0);
    end
    bus_respcyc = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
